// File: rtl/float_add_sub_if.sv
// Three-channel stb/ack stream bundle for the floating-point adder/subtractor.
interface float_add_sub_if #(
    parameter int unsigned W = 32
);
    logic [W-1:0] input_a;
    logic         input_a_stb;
    logic         input_a_ack;
    logic [W-1:0] input_b;
    logic         input_b_op;
    logic         input_b_stb;
    logic         input_b_ack;
    logic [W-1:0] output_z;
    logic [2:0]   output_z_flags;
    logic         output_z_stb;
    logic         output_z_ack;

    // Producer of operands and consumer of results.
    modport master (
        output input_a, input_a_stb, input_b, input_b_op, input_b_stb, output_z_ack,
        input  input_a_ack, input_b_ack, output_z, output_z_flags, output_z_stb
    );

    // The arithmetic unit.
    modport slave (
        input  input_a, input_a_stb, input_b, input_b_op, input_b_stb, output_z_ack,
        output input_a_ack, input_b_ack, output_z, output_z_flags, output_z_stb
    );
endinterface

// File: rtl/float_add_sub.sv
// Multi-cycle IEEE-754 adder/subtractor, round-to-nearest-even, stb/ack stream ports.
module float_add_sub #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
) (
    input  logic            clk,
    input  logic            rst,
    float_add_sub_if.slave  bus
);
    localparam int unsigned W  = 1 + EXP_W + MAN_W;
    localparam int unsigned MW = MAN_W + 4;   // hidden, fraction, G, R, S
    localparam int unsigned EW = EXP_W + 2;   // signed unbiased exponent
    localparam int          BIAS = 2 ** (EXP_W - 1) - 1;

    localparam logic signed [EW-1:0] E_BIAS    = EW'(BIAS);
    localparam logic signed [EW-1:0] E_MIN     = EW'(1 - BIAS);
    localparam logic signed [EW-1:0] E_ONE     = EW'(1);
    localparam logic signed [EW-1:0] ALIGN_MAX = EW'(MAN_W + 3);

    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [3:0] {
        ST_GET_A, ST_GET_B, ST_UNPACK, ST_SPECIAL_CASES, ST_ALIGN, ST_ADD_0,
        ST_ADD_1, ST_NORMALISE_1, ST_NORMALISE_2, ST_ROUND, ST_PACK, ST_PUT_Z
    } state_t;

    state_t                 state;
    logic [W-1:0]           a, b;
    logic                   op;
    logic [MW-1:0]          a_m, b_m, z_m;
    logic signed [EW-1:0]   a_e, b_e, z_e;
    logic                   a_s, b_s, z_s;
    logic [MW:0]            sum;
    logic                   inexact;

    logic                   a_exp_max, a_exp_zero, a_frac_nz, a_nan, a_snan, a_inf, a_zero;
    logic                   b_exp_max, b_exp_zero, b_frac_nz, b_nan, b_snan, b_inf, b_zero;
    logic signed [EW-1:0]   ab_diff, ba_diff;
    logic [MAN_W+1:0]       rnd_sum;

    // Operand classification straight from the captured encodings.
    always_comb begin
        a_exp_max  = &a[W-2:MAN_W];
        a_exp_zero = ~|a[W-2:MAN_W];
        a_frac_nz  = |a[MAN_W-1:0];
        a_nan      = a_exp_max && a_frac_nz;
        a_snan     = a_nan && !a[MAN_W-1];
        a_inf      = a_exp_max && !a_frac_nz;
        a_zero     = a_exp_zero && !a_frac_nz;
        b_exp_max  = &b[W-2:MAN_W];
        b_exp_zero = ~|b[W-2:MAN_W];
        b_frac_nz  = |b[MAN_W-1:0];
        b_nan      = b_exp_max && b_frac_nz;
        b_snan     = b_nan && !b[MAN_W-1];
        b_inf      = b_exp_max && !b_frac_nz;
        b_zero     = b_exp_zero && !b_frac_nz;
        ab_diff    = a_e - b_e;
        ba_diff    = b_e - a_e;
        rnd_sum    = {1'b0, z_m[MW-1:3]} + (MAN_W+2)'(1);
    end

    // Control FSM and datapath in one sequential process.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= ST_GET_A;
            bus.input_a_ack  <= 1'b0;
            bus.input_b_ack  <= 1'b0;
            bus.output_z_stb <= 1'b0;
        end else begin
            case (state)
                ST_GET_A: begin
                    bus.input_a_ack <= 1'b1;
                    if (bus.input_a_ack && bus.input_a_stb) begin
                        a               <= bus.input_a;
                        bus.input_a_ack <= 1'b0;
                        state           <= ST_GET_B;
                    end
                end
                ST_GET_B: begin
                    bus.input_b_ack <= 1'b1;
                    if (bus.input_b_ack && bus.input_b_stb) begin
                        b               <= bus.input_b;
                        op              <= bus.input_b_op;
                        bus.input_b_ack <= 1'b0;
                        state           <= ST_UNPACK;
                    end
                end
                ST_UNPACK: begin
                    a_m   <= {1'b0, a[MAN_W-1:0], 3'b000};
                    b_m   <= {1'b0, b[MAN_W-1:0], 3'b000};
                    a_e   <= EW'(a[W-2:MAN_W]) - E_BIAS;
                    b_e   <= EW'(b[W-2:MAN_W]) - E_BIAS;
                    a_s   <= a[W-1];
                    b_s   <= b[W-1] ^ op;
                    state <= ST_SPECIAL_CASES;
                end
                ST_SPECIAL_CASES: begin
                    state <= ST_PUT_Z;
                    bus.output_z_stb   <= 1'b1;
                    bus.output_z_flags <= 3'b000;
                    if (a_nan || b_nan) begin
                        bus.output_z       <= QNAN;
                        bus.output_z_flags <= {a_snan || b_snan, 2'b00};
                    end else if (a_inf && b_inf && (a_s != b_s)) begin
                        bus.output_z       <= QNAN;
                        bus.output_z_flags <= 3'b100;
                    end else if (a_inf) begin
                        bus.output_z <= {a_s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                    end else if (b_inf) begin
                        bus.output_z <= {b_s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                    end else if (a_zero && b_zero) begin
                        bus.output_z <= {a_s & b_s, {(W-1){1'b0}}};
                    end else if (a_zero) begin
                        bus.output_z <= {b_s, b[W-2:0]};
                    end else if (b_zero) begin
                        bus.output_z <= a;
                    end else begin
                        // Subnormals share the minimum exponent with a clear hidden bit.
                        bus.output_z_stb <= 1'b0;
                        state            <= ST_ALIGN;
                        if (a_exp_zero) a_e <= E_MIN;
                        else            a_m[MW-1] <= 1'b1;
                        if (b_exp_zero) b_e <= E_MIN;
                        else            b_m[MW-1] <= 1'b1;
                    end
                end
                ST_ALIGN: begin
                    // Far-apart operands collapse to a sticky bit in one step.
                    if (a_e > b_e) begin
                        b_e <= (ab_diff > ALIGN_MAX) ? a_e : b_e + E_ONE;
                        b_m <= (ab_diff > ALIGN_MAX) ? {{(MW-1){1'b0}}, |b_m}
                                                     : {1'b0, b_m[MW-1:2], b_m[1] | b_m[0]};
                    end else if (b_e > a_e) begin
                        a_e <= (ba_diff > ALIGN_MAX) ? b_e : a_e + E_ONE;
                        a_m <= (ba_diff > ALIGN_MAX) ? {{(MW-1){1'b0}}, |a_m}
                                                     : {1'b0, a_m[MW-1:2], a_m[1] | a_m[0]};
                    end else begin
                        state <= ST_ADD_0;
                    end
                end
                ST_ADD_0: begin
                    z_e   <= a_e;
                    state <= ST_ADD_1;
                    if (a_s == b_s) begin
                        sum <= {1'b0, a_m} + {1'b0, b_m};
                        z_s <= a_s;
                    end else if (a_m == b_m) begin
                        // Exact cancellation: +0 parked at the minimum exponent.
                        sum <= '0;
                        z_s <= 1'b0;
                        z_e <= E_MIN;
                    end else if (a_m > b_m) begin
                        sum <= {1'b0, a_m - b_m};
                        z_s <= a_s;
                    end else begin
                        sum <= {1'b0, b_m - a_m};
                        z_s <= b_s;
                    end
                end
                ST_ADD_1: begin
                    if (sum[MW]) begin
                        z_m <= {sum[MW:2], sum[1] | sum[0]};
                        z_e <= z_e + E_ONE;
                    end else begin
                        z_m <= sum[MW-1:0];
                    end
                    state <= ST_NORMALISE_1;
                end
                ST_NORMALISE_1: begin
                    if (!z_m[MW-1] && (z_e > E_MIN)) begin
                        z_m <= z_m << 1;
                        z_e <= z_e - E_ONE;
                    end else begin
                        state <= ST_NORMALISE_2;
                    end
                end
                ST_NORMALISE_2: begin
                    if (z_e < E_MIN) begin
                        z_m <= {1'b0, z_m[MW-1:2], z_m[1] | z_m[0]};
                        z_e <= z_e + E_ONE;
                    end else begin
                        state <= ST_ROUND;
                    end
                end
                ST_ROUND: begin
                    inexact <= |z_m[2:0];
                    if (z_m[2] && (z_m[1] || z_m[0] || z_m[3])) begin
                        if (rnd_sum[MAN_W+1]) begin
                            z_m[MW-1:3] <= {1'b1, {MAN_W{1'b0}}};
                            z_e         <= z_e + E_ONE;
                        end else begin
                            z_m[MW-1:3] <= rnd_sum[MAN_W:0];
                        end
                    end
                    state <= ST_PACK;
                end
                ST_PACK: begin
                    if (z_e > E_BIAS) begin
                        bus.output_z       <= {z_s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                        bus.output_z_flags <= 3'b011;
                    end else begin
                        bus.output_z       <= {z_s,
                                               (!z_m[MW-1] && (z_e == E_MIN)) ? {EXP_W{1'b0}}
                                                                             : EXP_W'(z_e + E_BIAS),
                                               z_m[MW-2:3]};
                        bus.output_z_flags <= {2'b00, inexact};
                    end
                    bus.output_z_stb <= 1'b1;
                    state            <= ST_PUT_Z;
                end
                ST_PUT_Z: begin
                    if (bus.output_z_stb && bus.output_z_ack) begin
                        bus.output_z_stb <= 1'b0;
                        state            <= ST_GET_A;
                    end
                end
                default: state <= ST_GET_A;
            endcase
        end
    end
endmodule

// File: tb/tb_float_add_sub.sv
// Directed self-checking bench for float_add_sub (binary32 plus one binary16 instance).
module tb_float_add_sub;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    float_add_sub_if #(.W(32)) bus ();
    float_add_sub_if #(.W(16)) bus16 ();

    float_add_sub dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    float_add_sub #(.EXP_W(5), .MAN_W(10)) dut16 (
        .clk (clk),
        .rst (rst),
        .bus (bus16)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // All tasks are entered right after a negedge.
    task automatic send_a(input logic [31:0] a);
        int n = 0;
        bus.input_a     = a;
        bus.input_a_stb = 1'b1;
        while (!bus.input_a_ack && n < 20) begin @(negedge clk); n++; end
        check("a_ack_timeout", 64'(n < 20), 64'd1);
        @(negedge clk);
        bus.input_a_stb = 1'b0;
    endtask

    task automatic send_b(input logic [31:0] b, input logic op);
        int n = 0;
        bus.input_b     = b;
        bus.input_b_op  = op;
        bus.input_b_stb = 1'b1;
        while (!bus.input_b_ack && n < 20) begin @(negedge clk); n++; end
        check("b_ack_timeout", 64'(n < 20), 64'd1);
        @(negedge clk);
        bus.input_b_stb = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic op, input logic [31:0] exp_z, input logic [2:0] exp_f,
                          input int hold, output int lat);
        send_a(a);
        send_b(b, op);
        lat = 0;
        while (!bus.output_z_stb && lat < 100) begin @(negedge clk); lat++; end
        check({tag, "_stb"}, 64'(bus.output_z_stb), 64'd1);
        check({tag, "_z"}, 64'(bus.output_z), 64'(exp_z));
        check({tag, "_flags"}, 64'(bus.output_z_flags), 64'(exp_f));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, "_hold_stb"}, 64'(bus.output_z_stb), 64'd1);
            check({tag, "_hold_z"}, 64'(bus.output_z), 64'(exp_z));
        end
        bus.output_z_ack = 1'b1;
        @(negedge clk);
        bus.output_z_ack = 1'b0;
        check({tag, "_stb_drop"}, 64'(bus.output_z_stb), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int n;
        bus.input_a = '0; bus.input_a_stb = 1'b0;
        bus.input_b = '0; bus.input_b_op = 1'b0; bus.input_b_stb = 1'b0;
        bus.output_z_ack = 1'b0;
        bus16.input_a = '0; bus16.input_a_stb = 1'b0;
        bus16.input_b = '0; bus16.input_b_op = 1'b0; bus16.input_b_stb = 1'b0;
        bus16.output_z_ack = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_a_ack", 64'(bus.input_a_ack), 64'd0);
        check("rst_b_ack", 64'(bus.input_b_ack), 64'd0);
        check("rst_z_stb", 64'(bus.output_z_stb), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("get_a_ack_rise", 64'(bus.input_a_ack), 64'd1);

        run_op("add_1_2",   32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 3'b000, 0, lat);
        run_op("cancel",    32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 3'b000, 0, lat);
        run_op("inf_ninf",  32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 3'b100, 0, lat);
        run_op("overflow",  32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b011, 0, lat);
        run_op("subnorm",   32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 3'b000, 0, lat);
        run_op("early_out", 32'h3F800000, 32'h21800000, 1'b0, 32'h3F800000, 3'b001, 5, lat);
        check("early_out_lat_le12", 64'(lat <= 12), 64'd1);
        run_op("qnan_in",   32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b000, 0, lat);
        run_op("snan_in",   32'h3F800000, 32'h7F800001, 1'b1, 32'h7FC00000, 3'b100, 0, lat);
        run_op("sub_neg",   32'h40000000, 32'h40400000, 1'b1, 32'hBF800000, 3'b000, 0, lat);
        run_op("zero_b",    32'h3F800000, 32'h80000000, 1'b0, 32'h3F800000, 3'b000, 0, lat);
        run_op("zero_a",    32'h00000000, 32'h3F800000, 1'b1, 32'hBF800000, 3'b000, 0, lat);
        run_op("pz_m_pz",   32'h00000000, 32'h00000000, 1'b1, 32'h00000000, 3'b000, 0, lat);
        run_op("nz_m_pz",   32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 3'b000, 0, lat);
        run_op("inf_m_1",   32'h7F800000, 32'h3F800000, 1'b1, 32'h7F800000, 3'b000, 0, lat);
        run_op("rne_tie_dn",32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 3'b001, 0, lat);
        run_op("ulp_add",   32'h3F800000, 32'h34000000, 1'b0, 32'h3F800001, 3'b000, 0, lat);
        run_op("rne_tie_up",32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 3'b001, 0, lat);
        run_op("borrow",    32'h3F800000, 32'h33800000, 1'b1, 32'h3F7FFFFF, 3'b000, 0, lat);
        check("borrow_lat_bound", 64'(lat <= 66), 64'd1);

        // Reset in the middle of a long alignment (1.0 + 2^-20).
        send_a(32'h3F800000);
        send_b(32'h35800000, 1'b0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_a_ack", 64'(bus.input_a_ack), 64'd0);
        check("midrst_b_ack", 64'(bus.input_b_ack), 64'd0);
        check("midrst_z_stb", 64'(bus.output_z_stb), 64'd0);
        @(negedge clk);
        check("midrst_get_a", 64'(bus.input_a_ack), 64'd1);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.output_z_stb) n++;
        end
        check("midrst_no_partial", 64'(n), 64'd0);
        run_op("after_rst", 32'h3F800000, 32'h35800000, 1'b0, 32'h3F800008, 3'b000, 0, lat);

        // binary16 instance: 1.0 + 1.0.
        bus16.input_a     = 16'h3C00;
        bus16.input_a_stb = 1'b1;
        n = 0;
        while (!bus16.input_a_ack && n < 20) begin @(negedge clk); n++; end
        @(negedge clk);
        bus16.input_a_stb = 1'b0;
        bus16.input_b     = 16'h3C00;
        bus16.input_b_op  = 1'b0;
        bus16.input_b_stb = 1'b1;
        while (!bus16.input_b_ack && n < 40) begin @(negedge clk); n++; end
        @(negedge clk);
        bus16.input_b_stb = 1'b0;
        while (!bus16.output_z_stb && n < 100) begin @(negedge clk); n++; end
        check("h_stb", 64'(bus16.output_z_stb), 64'd1);
        check("h_z", 64'(bus16.output_z), 64'h4000);
        check("h_flags", 64'(bus16.output_z_flags), 64'd0);
        bus16.output_z_ack = 1'b1;
        @(negedge clk);
        bus16.output_z_ack = 1'b0;
        check("h_stb_drop", 64'(bus16.output_z_stb), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/float_add_sub.md
Name: float_add_sub

Overview:
- Parametrised IEEE-754 floating-point adder/subtractor with a per-operation add/sub select and exception flags.
- Uses the same stb/ack three-channel handshake as the existing single-precision adder, so it drops into the same stream fabric.
- Default parameters give binary32; EXP_W=5/MAN_W=10 gives binary16, EXP_W=11/MAN_W=52 gives binary64.
- Round-to-nearest-even only.

Parameters:
EXP_W, 8, exponent field width (>=4)
MAN_W, 23, stored fraction width (>=4); W = 1+EXP_W+MAN_W, BIAS = 2^(EXP_W-1)-1 derived

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
input_a  in  W  operand a
input_a_stb  in  1  a valid
input_a_ack  out  1  a accepted
input_b  in  W  operand b
input_b_op  in  1  0=a+b, 1=a-b; sampled with input_b
input_b_stb  in  1  b valid
input_b_ack  out  1  b accepted
output_z  out  W  result
output_z_flags  out  3  {invalid, overflow, inexact}, qualified by output_z_stb
output_z_stb  out  1  z valid
output_z_ack  in  1  z accepted

Behaviour:
- Interface: one clock; reset is synchronous and active-high; ports named clk and rst.
- Reset: state<=get_a; input_a_ack, input_b_ack, output_z_stb <= 0. output_z/flags are undefined until the first put_z. Reset wins over any in-flight operation; a partial result is discarded and never presented.
- Handshake: in get_a, ack rises the cycle after entry. A transfer occurs on the edge where ack&&stb; ack drops the next cycle. Same for get_b, which also captures input_b_op.
- In put_z: stb rises with z/flags and both stay stable until the edge where stb&&ack. stb then drops and the FSM returns to get_a.
- One operation in flight; no pipelining.
- States: get_a -> get_b -> unpack -> special_cases -> (put_z | align) -> add_0 -> add_1 -> normalise_1 -> normalise_2 -> round -> pack -> put_z -> get_a.
- unpack:
  - Effective b sign = b_sign ^ op.
  - Exponents are held as signed EXP_W+2 bits, unbiased.
  - Mantissas are MAN_W+4 bits: hidden, fraction, G, R, S.
- special_cases, in priority order:
  - Any NaN -> canonical qNaN (sign 0, exp all ones, fraction MSB 1, rest 0). invalid=1 only if an input is sNaN (fraction MSB 0).
  - inf + (-inf) effective -> canonical qNaN, invalid=1.
  - Else any inf -> that inf.
  - Both zero -> zero with sign = a_s & b_s_eff.
  - One zero -> the other operand, with its effective sign.
  - Else go to align. Subnormals get exp = 1-BIAS and hidden bit 0; normals get hidden bit 1.
- align:
  - If |ea-eb| > MAN_W+3, the smaller operand collapses in one cycle: mantissa <= {0..0, S = OR of all its bits}, exponent <= the larger one.
  - Otherwise shift by 1 per cycle, ORing shifted-out bits into S.
  - Bound: <= MAN_W+4 align cycles.
- add_0:
  - Equal signs: sum = ma + mb, sign = a_s.
  - Unequal signs: larger minus smaller, sign of the larger.
  - Exact zero difference -> +0.
  - sum is MAN_W+5 bits.
- add_1: on carry-out, take the upper bits and increment the exponent; S absorbs the dropped bits.
- normalise_1: left-shift 1/cycle while hidden==0 and exp > 1-BIAS.
- normalise_2: right-shift 1/cycle while exp < 1-BIAS, maintaining G/R/S.
- round: RNE, increment if G && (R|S|lsb). Mantissa overflow re-normalises and increments the exponent.
- pack:
  - exp > BIAS -> +/-inf, overflow=1, inexact=1.
  - exp == 1-BIAS && hidden==0 -> biased exponent 0 (subnormal/zero).
  - inexact = G|R|S before rounding.
  - Special-case results: overflow=0 and inexact=0.
- Latency from b transfer to stb rise: 9 + align cycles + normalise cycles; at most 2*MAN_W+20.

Test Plan:
- Add, 1.0+2.0: a=0x3F800000, b=0x40000000, op=0 -> z=0x40400000, flags=000.
- Exact cancel, 1.0-1.0: a=0x3F800000, b=0x3F800000, op=1 -> z=0x00000000 (+0), flags=000.
- Invalid: inf+(-inf) (0x7F800000 + 0xFF800000, op=0) -> z=0x7FC00000, flags=100.
- Overflow: 0x7F7FFFFF + 0x7F7FFFFF -> z=0x7F800000, flags=011. Separately, subnormals 0x00000001 + 0x00000001 -> z=0x00000002, flags=000.
- Align early-out: 1.0 + 2^-60 (0x21800000) -> z=0x3F800000, flags=001; stb within 12 cycles of the b transfer. Also hold output_z_ack=0 for 5 cycles and check z/stb stay stable.
- Parametrisation and reset:
  - EXP_W=5, MAN_W=10: 0x3C00 + 0x3C00 -> 0x4000.
  - Assert rst during align -> next cycle acks/stb=0, FSM in get_a; the following transaction is correct.
